// File: rtl/fwd_hazard_unit_pkg.sv
// Package: fwd_pkg
// Shared constants for the ID-stage forwarding/hazard unit.
//   FWD_RF      : select code for "read the register file"
//   fwd_ll()    : select code for the long-latency completion bus
//   CLS_INT/FP  : register class encodings (int / float)
//   stg_lo()    : low bit of stage i inside a packed stage vector
package fwd_pkg;
  localparam int   FWD_RF  = 0;
  localparam logic CLS_INT = 1'b0;
  localparam logic CLS_FP  = 1'b1;

  // Completion bus sits just above the stage codes 1..num_stages.
  function automatic int fwd_ll(int num_stages);
    return num_stages + 1;
  endfunction

  function automatic int stg_lo(int idx, int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Interface: fwd_hazard_unit_if
// Groups the ID-side operand request, in-flight stage descriptors,
// long-latency issue/completion and the forwarding/stall results.
//   master : decoder / pipeline side (drives requests, reads selects)
//   slave  : fwd_hazard_unit
interface fwd_hazard_unit_if #(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 5,
  parameter int SEL_W      = 3
);
  logic [REG_W-1:0]            rs1_id;
  logic [REG_W-1:0]            rs2_id;
  logic [1:0]                  rs_fp;
  logic [NUM_STAGES-1:0]       stg_we;
  logic [NUM_STAGES*REG_W-1:0] stg_rd;
  logic [NUM_STAGES-1:0]       stg_fp;
  logic [NUM_STAGES-1:0]       stg_ld;
  logic                        ll_issue;
  logic [REG_W-1:0]            ll_rd;
  logic                        ll_fp;
  logic                        ll_done;
  logic [REG_W-1:0]            ll_done_rd;
  logic                        ll_done_fp;
  logic [SEL_W-1:0]            fa;
  logic [SEL_W-1:0]            fb;
  logic                        fa_ld;
  logic                        fb_ld;
  logic                        stall;
  logic [REG_W:0]              ll_busy_cnt;

  modport master (
    output rs1_id, rs2_id, rs_fp, stg_we, stg_rd, stg_fp, stg_ld,
           ll_issue, ll_rd, ll_fp, ll_done, ll_done_rd, ll_done_fp,
    input  fa, fb, fa_ld, fb_ld, stall, ll_busy_cnt
  );
  modport slave (
    input  rs1_id, rs2_id, rs_fp, stg_we, stg_rd, stg_fp, stg_ld,
           ll_issue, ll_rd, ll_fp, ll_done, ll_done_rd, ll_done_fp,
    output fa, fb, fa_ld, fb_ld, stall, ll_busy_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_ll_scoreboard.sv
// Module: ll_scoreboard
// Busy bit per (class, reg) for results owed by long-latency units,
// plus a registered population count.
//   clk, rst        : clock, synchronous active-high reset
//   ll_issue_i/rd/fp: op leaving ID, sets its destination busy
//   ll_done_i/rd/fp : completion, clears its destination
//   busy_o          : busy table [class][reg]
//   cnt_o           : number of busy entries
module ll_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ll_issue_i,
  input  logic [REG_W-1:0]             ll_rd_i,
  input  logic                         ll_fp_i,
  input  logic                         ll_done_i,
  input  logic [REG_W-1:0]             ll_done_rd_i,
  input  logic                         ll_done_fp_i,
  output logic [1:0][NUM_REGS-1:0]     busy_o,
  output logic [REG_W:0]               cnt_o
);
  logic [1:0][NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_W:0]           cnt_q, cnt_d;
  logic                     iss_ok, same, set, clr;

  always_comb begin
    // x0 is hard-wired zero, never owed by anyone.
    iss_ok = ll_issue_i && !(ll_fp_i == CLS_INT && ll_rd_i == '0);
    same   = iss_ok && (ll_done_fp_i == ll_fp_i) && (ll_done_rd_i == ll_rd_i);
    // A set of an already-busy entry (WAW) is a no-op.
    set    = iss_ok && !busy_q[ll_fp_i][ll_rd_i];
    // Completions of idle entries (e.g. ops in flight across a reset) are
    // dropped so the count cannot underflow. Issue wins on same entry.
    clr    = ll_done_i && busy_q[ll_done_fp_i][ll_done_rd_i] && !same;
    busy_d = busy_q;
    if (clr) busy_d[ll_done_fp_i][ll_done_rd_i] = 1'b0;
    if (set) busy_d[ll_fp_i][ll_rd_i] = 1'b1;
    cnt_d  = cnt_q + (REG_W+1)'(set) - (REG_W+1)'(clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/fwd_hazard_unit.sv
// Module: fwd_hazard_unit
// ID-stage operand forwarding select and stall generation.
//   clk, rst : clock, synchronous active-high reset
//   hif      : fwd_hazard_unit_if.slave (operand indices/classes, stage
//              descriptors, long-latency issue/done; fa/fb selects,
//              fa_ld/fb_ld, stall, ll_busy_cnt)
// Selects: 0 = regfile, i+1 = stage i (0 youngest), NUM_STAGES+1 = LL bus.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 5,
  parameter int NUM_REGS   = 32,
  parameter int SEL_W      = 3
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave hif
);
  logic [1:0][REG_W-1:0]      rs;
  logic [1:0]                 op_fp;
  logic [1:0]                 x0, done_hit, ld_use, sb_stall, sel_ld;
  logic [1:0][NUM_STAGES-1:0] hit;
  logic [1:0][SEL_W-1:0]      sel;
  logic [1:0][NUM_REGS-1:0]   busy;
  logic                       waw;

  // Operand 0 = A (rs1, class rs_fp[1]), operand 1 = B (rs2, class rs_fp[0]).
  assign rs[0]    = hif.rs1_id;
  assign rs[1]    = hif.rs2_id;
  assign op_fp[0] = hif.rs_fp[1];
  assign op_fp[1] = hif.rs_fp[0];

  ll_scoreboard #(.REG_W(REG_W), .NUM_REGS(NUM_REGS)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .ll_issue_i   (hif.ll_issue),
    .ll_rd_i      (hif.ll_rd),
    .ll_fp_i      (hif.ll_fp),
    .ll_done_i    (hif.ll_done),
    .ll_done_rd_i (hif.ll_done_rd),
    .ll_done_fp_i (hif.ll_done_fp),
    .busy_o       (busy),
    .cnt_o        (hif.ll_busy_cnt)
  );

  always_comb begin
    x0       = '0;
    done_hit = '0;
    hit      = '0;
    sel      = '0;
    sel_ld   = '0;
    ld_use   = '0;
    sb_stall = '0;
    for (int g = 0; g < 2; g++) begin
      x0[g]       = (op_fp[g] == CLS_INT) && (rs[g] == '0);
      done_hit[g] = hif.ll_done && (hif.ll_done_rd == rs[g]) &&
                    (hif.ll_done_fp == op_fp[g]) && !x0[g];
      for (int i = 0; i < NUM_STAGES; i++)
        hit[g][i] = hif.stg_we[i] && !x0[g] && (hif.stg_fp[i] == op_fp[g]) &&
                    (hif.stg_rd[stg_lo(i, REG_W) +: REG_W] == rs[g]);
      sel[g] = done_hit[g] ? SEL_W'(fwd_ll(NUM_STAGES)) : SEL_W'(FWD_RF);
      // Walk oldest to youngest so the youngest match is the last write.
      for (int i = NUM_STAGES - 1; i >= 0; i--)
        if (hit[g][i]) begin
          sel[g]    = SEL_W'(i + 1);
          sel_ld[g] = hif.stg_ld[i];
        end
      ld_use[g]   = hit[g][0] && hif.stg_ld[0];
      // A same-cycle completion of the busy entry is forwarded, not stalled.
      sb_stall[g] = busy[op_fp[g]][rs[g]] && !done_hit[g];
    end
  end

  assign waw       = hif.ll_issue && busy[hif.ll_fp][hif.ll_rd];
  assign hif.fa    = sel[0];
  assign hif.fb    = sel[1];
  assign hif.fa_ld = sel_ld[0];
  assign hif.fb_ld = sel_ld[1];
  assign hif.stall = (|ld_use) || (|sb_stall) || waw;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_STAGES(3), .REG_W(5), .SEL_W(3)) hif ();

  fwd_hazard_unit #(.NUM_STAGES(3), .REG_W(5), .NUM_REGS(32), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [1:0]  rs_fp;
    logic [2:0]  we, fp, ld;
    logic [14:0] rd;
    logic [2:0]  fa, fb;
    logic        fa_ld, fb_ld, stall;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.rs1_id = 5'd1; hif.rs2_id = 5'd2; hif.rs_fp = 2'b00;
    hif.stg_we = '0; hif.stg_rd = '0; hif.stg_fp = '0; hif.stg_ld = '0;
    hif.ll_issue = 1'b0; hif.ll_rd = '0; hif.ll_fp = 1'b0;
    hif.ll_done = 1'b0; hif.ll_done_rd = '0; hif.ll_done_fp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          rs1  rs2  fp    we      fp      ld      rd {s2,s1,s0}          fa fb fald fbld stall
    tv[0] = '{5'd5, 5'd1, 2'b00, 3'b011, 3'b000, 3'b000, {5'd0, 5'd5, 5'd5}, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{5'd5, 5'd1, 2'b00, 3'b010, 3'b000, 3'b000, {5'd0, 5'd5, 5'd5}, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{5'd2, 5'd7, 2'b00, 3'b001, 3'b000, 3'b001, {5'd0, 5'd0, 5'd7}, 3'd0, 3'd1, 1'b0, 1'b1, 1'b1};
    tv[3] = '{5'd2, 5'd7, 2'b01, 3'b001, 3'b000, 3'b001, {5'd0, 5'd0, 5'd7}, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[4] = '{5'd0, 5'd1, 2'b00, 3'b100, 3'b000, 3'b000, {5'd0, 5'd0, 5'd0}, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[5] = '{5'd0, 5'd1, 2'b10, 3'b100, 3'b100, 3'b000, {5'd0, 5'd0, 5'd0}, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[6] = '{5'd4, 5'd4, 2'b00, 3'b111, 3'b000, 3'b100, {5'd4, 5'd4, 5'd4}, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0};
    tv[7] = '{5'd1, 5'd6, 2'b00, 3'b110, 3'b000, 3'b010, {5'd6, 5'd6, 5'd0}, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0};
    tv[8] = '{5'd8, 5'd8, 2'b01, 3'b011, 3'b001, 3'b000, {5'd0, 5'd8, 5'd8}, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0};
    tv[9] = '{5'd3, 5'd3, 2'b11, 3'b000, 3'b111, 3'b111, {5'd3, 5'd3, 5'd3}, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

    idle();
    tick(); tick();
    chk("reset_cnt", hif.ll_busy_cnt, 0);
    chk("reset_stall", hif.stall, 0);
    chk("reset_fa", hif.fa, 0);
    rst = 1'b0;
    tick();

    // Combinational forwarding table, scoreboard empty.
    for (int k = 0; k < 10; k++) begin
      hif.rs1_id = tv[k].rs1; hif.rs2_id = tv[k].rs2; hif.rs_fp = tv[k].rs_fp;
      hif.stg_we = tv[k].we;  hif.stg_fp = tv[k].fp;  hif.stg_ld = tv[k].ld;
      hif.stg_rd = tv[k].rd;
      #2;
      chk($sformatf("v%0d_fa", k), hif.fa, tv[k].fa);
      chk($sformatf("v%0d_fb", k), hif.fb, tv[k].fb);
      chk($sformatf("v%0d_fa_ld", k), hif.fa_ld, tv[k].fa_ld);
      chk($sformatf("v%0d_fb_ld", k), hif.fb_ld, tv[k].fb_ld);
      chk($sformatf("v%0d_stall", k), hif.stall, tv[k].stall);
    end

    // Long-latency issue of f9, then a dependent read.
    idle();
    tick();
    hif.ll_issue = 1'b1; hif.ll_rd = 5'd9; hif.ll_fp = 1'b1;
    #1 chk("issue_no_stall", hif.stall, 0);
    tick();
    hif.ll_issue = 1'b0;
    hif.rs1_id = 5'd9; hif.rs_fp = 2'b10;
    #1 chk("sb_stall", hif.stall, 1);
    chk("cnt_after_issue", hif.ll_busy_cnt, 1);
    chk("sb_fa_rf", hif.fa, 0);

    // WAW on f9 while it is still busy.
    hif.rs1_id = 5'd1; hif.rs_fp = 2'b00;
    hif.ll_issue = 1'b1; hif.ll_rd = 5'd9; hif.ll_fp = 1'b1;
    #1 chk("waw_stall", hif.stall, 1);
    tick();
    hif.ll_issue = 1'b0;
    #1 chk("waw_cnt", hif.ll_busy_cnt, 1);

    // Completion of f9 forwards from the bus in the same cycle.
    hif.rs1_id = 5'd9; hif.rs_fp = 2'b10;
    hif.ll_done = 1'b1; hif.ll_done_rd = 5'd9; hif.ll_done_fp = 1'b1;
    #1 chk("done_fa", hif.fa, 4);
    chk("done_fa_ld", hif.fa_ld, 0);
    chk("done_stall", hif.stall, 0);
    tick();
    hif.ll_done = 1'b0;
    #1 chk("cleared_cnt", hif.ll_busy_cnt, 0);
    chk("cleared_stall", hif.stall, 0);
    chk("cleared_fa", hif.fa, 0);

    // Issue x0 is ignored.
    hif.ll_issue = 1'b1; hif.ll_rd = 5'd0; hif.ll_fp = 1'b0;
    tick();
    hif.ll_issue = 1'b0;
    #1 chk("x0_cnt", hif.ll_busy_cnt, 0);

    // x3 busy, then issue+done of x3 in one cycle: stays busy.
    hif.ll_issue = 1'b1; hif.ll_rd = 5'd3; hif.ll_fp = 1'b0;
    tick();
    #1 chk("x3_cnt", hif.ll_busy_cnt, 1);
    hif.ll_done = 1'b1; hif.ll_done_rd = 5'd3; hif.ll_done_fp = 1'b0;
    tick();
    hif.ll_issue = 1'b0; hif.ll_done = 1'b0;
    hif.rs1_id = 5'd3; hif.rs_fp = 2'b00;
    #1 chk("same_cnt", hif.ll_busy_cnt, 1);
    chk("same_busy_stall", hif.stall, 1);

    // Fill three entries then reset mid-operation.
    hif.rs1_id = 5'd1;
    hif.ll_issue = 1'b1; hif.ll_rd = 5'd10; hif.ll_fp = 1'b1;
    tick();
    hif.ll_rd = 5'd11; hif.ll_fp = 1'b0;
    tick();
    hif.ll_issue = 1'b0;
    #1 chk("three_cnt", hif.ll_busy_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hif.rs1_id = 5'd3; hif.rs2_id = 5'd11; hif.rs_fp = 2'b00;
    #1 chk("rst_cnt", hif.ll_busy_cnt, 0);
    chk("rst_stall", hif.stall, 0);
    chk("rst_fb", hif.fb, 0);

    // Stale completion from before reset must not underflow.
    hif.ll_done = 1'b1; hif.ll_done_rd = 5'd3; hif.ll_done_fp = 1'b0;
    tick();
    hif.ll_done = 1'b0;
    #1 chk("stale_cnt", hif.ll_busy_cnt, 0);
    chk("stale_stall", hif.stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
